// File: rtl/collision_arbiter.sv
// collision_arbiter
// Watches the ball against walls, paddles and goal lines. Each clock it raises
// at most one bounce request to the ball FSM and keeps the two player scores.
// Optional feature: define BOUNCE_ACK_TIMEOUT_EN to release a held bounce after
// ACK_TIMEOUT clocks without acknowledge. Default build: wait indefinitely.
module collision_arbiter #(
   parameter int SCREEN_X    = 640,
   parameter int SCREEN_Y    = 480,
   parameter int PADDLE_L_X  = 16,
   parameter int PADDLE_R_X  = 616,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_H    = 64,
   parameter int WIN_SCORE   = 9,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic [7:0] ball_w,
   input  logic [7:0] ball_h,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   input  logic       restart,
   output logic [1:0] bounce,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over
);

   // Bounce codes sent to the ball FSM
   localparam logic [1:0] BOUNCE_NONE   = 2'b00;
   localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
   localparam logic [1:0] BOUNCE_WALL   = 2'b10;
   localparam logic [1:0] BOUNCE_SERVE  = 2'b11;

   // Geometry constants, all 11 bits so sums of 10-bit positions never wrap
   localparam logic [10:0] SCREEN_X_W     = 11'(SCREEN_X);
   localparam logic [10:0] SCREEN_Y_W     = 11'(SCREEN_Y);
   localparam logic [10:0] PADDLE_L_LEFT  = 11'(PADDLE_L_X);
   localparam logic [10:0] PADDLE_L_RIGHT = 11'(PADDLE_L_X + PADDLE_W);
   localparam logic [10:0] PADDLE_R_LEFT  = 11'(PADDLE_R_X);
   localparam logic [10:0] PADDLE_R_RIGHT = 11'(PADDLE_R_X + PADDLE_W);
   localparam logic [10:0] PADDLE_H_W     = 11'(PADDLE_H);
   localparam logic [3:0]  WIN            = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      WATCH     = 2'd0,
      HOLD      = 2'd1,
      SERVE     = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   // True when the half-open vertical spans [a_top,a_bot) and [b_top,b_bot) intersect
   function automatic logic span_overlap(input logic [10:0] a_top, input logic [10:0] a_bot,
                                         input logic [10:0] b_top, input logic [10:0] b_bot);
      return (a_top < b_bot) && (a_bot > b_top);
   endfunction

   // Score after a goal, saturating at the winning score
   function automatic logic [3:0] score_step(input logic [3:0] s);
      logic [3:0] r;
      if (s >= WIN) begin
         r = WIN;
      end else begin
         r = s + 4'd1;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Edge positions and collision conditions
   // ---------------------------------------------------------------------
   logic [10:0] ball_left_s;
   logic [10:0] ball_right_s;
   logic [10:0] ball_top_s;
   logic [10:0] ball_bottom_s;
   logic [10:0] pl_top_s;
   logic [10:0] pl_bottom_s;
   logic [10:0] pr_top_s;
   logic [10:0] pr_bottom_s;

   logic wall_s;
   logic paddle_l_s;
   logic paddle_r_s;
   logic goal_l_s;
   logic goal_r_s;

   assign ball_left_s   = {1'b0, ball_x};
   assign ball_right_s  = {1'b0, ball_x} + {3'b000, ball_w};
   assign ball_top_s    = {1'b0, ball_y};
   assign ball_bottom_s = {1'b0, ball_y} + {3'b000, ball_h};
   assign pl_top_s      = {1'b0, paddle_l_y};
   assign pl_bottom_s   = {1'b0, paddle_l_y} + PADDLE_H_W;
   assign pr_top_s      = {1'b0, paddle_r_y};
   assign pr_bottom_s   = {1'b0, paddle_r_y} + PADDLE_H_W;

   assign wall_s     = (ball_y == 10'd0) || (ball_bottom_s >= SCREEN_Y_W);
   assign paddle_l_s = (ball_left_s <= PADDLE_L_RIGHT) && (ball_right_s > PADDLE_L_LEFT) &&
                       span_overlap(ball_top_s, ball_bottom_s, pl_top_s, pl_bottom_s);
   assign paddle_r_s = (ball_left_s <= PADDLE_R_RIGHT) && (ball_right_s > PADDLE_R_LEFT) &&
                       span_overlap(ball_top_s, ball_bottom_s, pr_top_s, pr_bottom_s);
   assign goal_l_s   = (ball_x == 10'd0);
   assign goal_r_s   = (ball_right_s >= SCREEN_X_W);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t     state_r,      state_n;
   logic [1:0] bounce_r,     bounce_n;
   logic [3:0] score_left_r, score_left_n;
   logic [3:0] score_right_r, score_right_n;
   logic       game_over_r,  game_over_n;
   logic [9:0] snap_x_r,     snap_x_n;
   logic [9:0] snap_y_r,     snap_y_n;
   logic       wall_arm_r,   wall_arm_n;
   logic       pl_arm_r,     pl_arm_n;
   logic       pr_arm_r,     pr_arm_n;

   logic       ack_s;
   logic       timeout_s;
   logic       waiting_s;
   logic [3:0] score_left_inc_s;
   logic [3:0] score_right_inc_s;

   // The ball FSM acknowledges a bounce by moving the ball off the snapshot
   assign ack_s             = (ball_x != snap_x_r) || (ball_y != snap_y_r);
   assign waiting_s         = (state_r == HOLD) || (state_r == SERVE);
   assign score_left_inc_s  = score_step(score_left_r);
   assign score_right_inc_s = score_step(score_right_r);

`ifdef BOUNCE_ACK_TIMEOUT_EN
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

   logic [7:0] ack_cnt_r, ack_cnt_n;

   assign timeout_s = waiting_s && !ack_s && (ack_cnt_r == ACK_LAST);

   // Count clocks spent waiting for acknowledge; cleared whenever not waiting
   always_comb begin
      ack_cnt_n = 8'd0;
      if (waiting_s && !ack_s && !timeout_s) begin
         ack_cnt_n = ack_cnt_r + 8'd1;
      end else begin
         ack_cnt_n = 8'd0;
      end
   end

   // Acknowledge timeout counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         ack_cnt_r <= 8'd0;
      end else begin
         ack_cnt_r <= ack_cnt_n;
      end
   end
`else
   // Without the timeout option a held bounce waits for acknowledge forever
   logic [7:0] unused_ack_timeout_s;
   assign unused_ack_timeout_s = 8'(ACK_TIMEOUT);
   assign timeout_s            = 1'b0;
`endif

   // Next-state, bounce, score and arming decisions
   always_comb begin
      state_n       = state_r;
      bounce_n      = bounce_r;
      score_left_n  = score_left_r;
      score_right_n = score_right_r;
      game_over_n   = game_over_r;
      snap_x_n      = snap_x_r;
      snap_y_n      = snap_y_r;
      // A disarmed source re-arms once its condition has been false for a clock
      wall_arm_n    = wall_arm_r | ~wall_s;
      pl_arm_n      = pl_arm_r   | ~paddle_l_s;
      pr_arm_n      = pr_arm_r   | ~paddle_r_s;

      case (state_r)
         WATCH: begin
            bounce_n = BOUNCE_NONE;
            if (goal_l_s) begin
               // Ball crossed the left line: point to the right player
               score_right_n = score_right_inc_s;
               bounce_n      = BOUNCE_SERVE;
               snap_x_n      = ball_x;
               snap_y_n      = ball_y;
               if (score_right_inc_s == WIN) begin
                  state_n     = GAME_OVER;
                  game_over_n = 1'b1;
               end else begin
                  state_n     = SERVE;
               end
            end else if (goal_r_s) begin
               score_left_n = score_left_inc_s;
               bounce_n     = BOUNCE_SERVE;
               snap_x_n     = ball_x;
               snap_y_n     = ball_y;
               if (score_left_inc_s == WIN) begin
                  state_n     = GAME_OVER;
                  game_over_n = 1'b1;
               end else begin
                  state_n     = SERVE;
               end
            end else if (paddle_l_s && pl_arm_r) begin
               bounce_n = BOUNCE_PADDLE;
               pl_arm_n = 1'b0;
               snap_x_n = ball_x;
               snap_y_n = ball_y;
               state_n  = HOLD;
            end else if (paddle_r_s && pr_arm_r) begin
               bounce_n = BOUNCE_PADDLE;
               pr_arm_n = 1'b0;
               snap_x_n = ball_x;
               snap_y_n = ball_y;
               state_n  = HOLD;
            end else if (wall_s && wall_arm_r) begin
               bounce_n   = BOUNCE_WALL;
               wall_arm_n = 1'b0;
               snap_x_n   = ball_x;
               snap_y_n   = ball_y;
               state_n    = HOLD;
            end else begin
               state_n = WATCH;
            end
         end
         HOLD, SERVE: begin
            // Bounce stays asserted until the ball moves or the wait times out
            if (ack_s || timeout_s) begin
               bounce_n = BOUNCE_NONE;
               state_n  = WATCH;
            end else begin
               state_n  = state_r;
            end
         end
         GAME_OVER: begin
            bounce_n    = BOUNCE_SERVE;
            game_over_n = 1'b1;
            if (restart) begin
               score_left_n  = 4'd0;
               score_right_n = 4'd0;
               game_over_n   = 1'b0;
               wall_arm_n    = 1'b1;
               pl_arm_n      = 1'b1;
               pr_arm_n      = 1'b1;
               snap_x_n      = ball_x;
               snap_y_n      = ball_y;
               state_n       = SERVE;
            end else begin
               state_n       = GAME_OVER;
            end
         end
         default: begin
            bounce_n = BOUNCE_NONE;
            state_n  = WATCH;
         end
      endcase
   end

   // State and output registers; reset wins over everything else
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= WATCH;
         bounce_r      <= BOUNCE_NONE;
         score_left_r  <= 4'd0;
         score_right_r <= 4'd0;
         game_over_r   <= 1'b0;
         snap_x_r      <= 10'd0;
         snap_y_r      <= 10'd0;
         wall_arm_r    <= 1'b1;
         pl_arm_r      <= 1'b1;
         pr_arm_r      <= 1'b1;
      end else begin
         state_r       <= state_n;
         bounce_r      <= bounce_n;
         score_left_r  <= score_left_n;
         score_right_r <= score_right_n;
         game_over_r   <= game_over_n;
         snap_x_r      <= snap_x_n;
         snap_y_r      <= snap_y_n;
         wall_arm_r    <= wall_arm_n;
         pl_arm_r      <= pl_arm_n;
         pr_arm_r      <= pr_arm_n;
      end
   end

   assign bounce    = bounce_r;
   assign score_l   = score_left_r;
   assign score_r   = score_right_r;
   assign game_over = game_over_r;

endmodule
